// File: rtl/rtc_bcd_pkg.sv
// Shared constants and BCD helpers for the real-time-clock core.
package rtc_bcd_pkg;

  // Write target selectors carried on i_sel.
  localparam logic [1:0] SEL_SS = 2'd0;
  localparam logic [1:0] SEL_MM = 2'd1;
  localparam logic [1:0] SEL_HH = 2'd2;
  localparam logic [1:0] SEL_PM = 2'd3;

  // BCD field limits.
  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_23 = 8'h23;
  localparam logic [7:0] BCD_12 = 8'h12;

  // True when both nibbles are legal decimal digits.
  function automatic logic bcd_digits_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Increment a two-digit BCD value; wrap handling is left to the caller.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] >= 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Two-digit BCD to binary (0..99).
  function automatic logic [6:0] bcd_to_bin(input logic [7:0] v);
    return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
  endfunction

  // Binary (0..99) to two-digit BCD.
  function automatic logic [7:0] bin_to_bcd(input logic [6:0] b);
    return {4'(b / 7'd10), 4'(b % 7'd10)};
  endfunction

  // Hour shift between 12h PM and 24h afternoon representations.
  function automatic logic [7:0] bcd_add12(input logic [7:0] v);
    return bin_to_bcd(bcd_to_bin(v) + 7'd12);
  endfunction

  function automatic logic [7:0] bcd_sub12(input logic [7:0] v);
    return bin_to_bcd(bcd_to_bin(v) - 7'd12);
  endfunction

endpackage

// File: rtl/rtc_bcd_field.sv
// Two-digit BCD counter 00..MAX with parallel load and a carry-out
// that fires on the advance that wraps MAX back to 00.
module rtc_bcd_field
  import rtc_bcd_pkg::*;
#(
  parameter logic [7:0] MAX = BCD_59
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_inc,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  output logic [7:0] o_val,
  output logic       o_carry
);

  assign o_carry = i_inc && (o_val == MAX);

  // Load has priority over advance; the core never asserts both together.
  always_ff @(posedge i_clk) begin
    if (i_reset)      o_val <= 8'h00;
    else if (i_load)  o_val <= i_load_val;
    else if (i_inc)   o_val <= o_carry ? 8'h00 : bcd_inc(o_val);
  end

endmodule

// File: rtl/rtc_bcd_core.sv
// BCD real-time clock: prescaler, ss/mm/hh fields, 12h/24h conversion and
// a validated field write port.
//
// Write port: i_wr is a single-cycle strobe with no back-pressure. A write
// is accepted (i_sel/i_in sampled) on the edge where i_wr=1; a rejected
// write leaves all state untouched and pulses o_wr_err on the next cycle.
module rtc_bcd_core
  import rtc_bcd_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int PRESC_W = 24
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ena,
  input  logic       i_mode_24h,
  input  logic       i_wr,
  input  logic [1:0] i_sel,
  input  logic [7:0] i_in,
  output logic [7:0] o_ss,
  output logic [7:0] o_mm,
  output logic [7:0] o_hh,
  output logic       o_pm,
  output logic       o_tick,
  output logic       o_day_wrap,
  output logic       o_wr_err
);

  logic [PRESC_W-1:0] presc;
  logic               r_mode;
  logic               mode_chg;
  logic               presc_last;
  logic               tick_int;
  logic               wr_valid;
  logic               wr_ok;
  logic               wr_rej;
  logic               ss_carry;
  logic               mm_carry;

  // A mode change owns the cycle; writes and counting wait behind it.
  assign mode_chg   = (i_mode_24h != r_mode);
  assign presc_last = (presc == PRESC_W'(CLK_DIV - 1));
  assign tick_int   = i_ena && presc_last && !mode_chg && !i_wr;
  assign wr_ok      = i_wr && !mode_chg && wr_valid;
  assign wr_rej     = i_wr && (mode_chg || !wr_valid);

  // Field-specific legality of the write data against the current mode.
  always_comb begin
    wr_valid = 1'b0;
    case (i_sel)
      SEL_SS, SEL_MM: wr_valid = bcd_digits_ok(i_in) && (i_in <= BCD_59);
      SEL_HH: begin
        if (r_mode) wr_valid = bcd_digits_ok(i_in) && (i_in <= BCD_23);
        else        wr_valid = bcd_digits_ok(i_in) && (i_in != 8'h00) && (i_in <= BCD_12);
      end
      SEL_PM:  wr_valid = !r_mode;
      default: wr_valid = 1'b0;
    endcase
  end

  // Prescaler: holds across conversions and writes, cleared by a seconds write.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      presc <= '0;
    end else if (mode_chg) begin
      presc <= presc;
    end else if (i_wr) begin
      if (wr_ok && (i_sel == SEL_SS)) presc <= '0;
    end else if (i_ena) begin
      presc <= presc_last ? '0 : presc + PRESC_W'(1);
    end
  end

  rtc_bcd_field #(.MAX(BCD_59)) u_ss (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_inc      (tick_int),
    .i_load     (wr_ok && (i_sel == SEL_SS)),
    .i_load_val (i_in),
    .o_val      (o_ss),
    .o_carry    (ss_carry)
  );

  rtc_bcd_field #(.MAX(BCD_59)) u_mm (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_inc      (ss_carry),
    .i_load     (wr_ok && (i_sel == SEL_MM)),
    .i_load_val (i_in),
    .o_val      (o_mm),
    .o_carry    (mm_carry)
  );

  // Hours, PM flag, mode register and the single-cycle status pulses.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mode     <= i_mode_24h;
      o_hh       <= i_mode_24h ? 8'h00 : BCD_12;
      o_pm       <= 1'b0;
      o_tick     <= 1'b0;
      o_day_wrap <= 1'b0;
      o_wr_err   <= 1'b0;
    end else begin
      r_mode     <= i_mode_24h;
      o_tick     <= tick_int;
      o_wr_err   <= wr_rej;
      o_day_wrap <= 1'b0;
      if (mode_chg) begin
        if (i_mode_24h) begin
          // 12h -> 24h: the PM flag already equals (hh >= 12) afterwards.
          if (o_hh == BCD_12) o_hh <= o_pm ? BCD_12 : 8'h00;
          else if (o_pm)      o_hh <= bcd_add12(o_hh);
        end else begin
          // 24h -> 12h
          o_pm <= (o_hh >= BCD_12);
          if (o_hh == 8'h00)       o_hh <= BCD_12;
          else if (o_hh > BCD_12)  o_hh <= bcd_sub12(o_hh);
        end
      end else if (wr_ok) begin
        if (i_sel == SEL_HH) begin
          o_hh <= i_in;
          if (r_mode) o_pm <= (i_in >= BCD_12);
        end else if (i_sel == SEL_PM) begin
          o_pm <= i_in[0];
        end
      end else if (mm_carry) begin
        if (r_mode) begin
          if (o_hh == BCD_23) begin
            o_hh       <= 8'h00;
            o_pm       <= 1'b0;
            o_day_wrap <= 1'b1;
          end else begin
            o_hh <= bcd_inc(o_hh);
            o_pm <= (bcd_inc(o_hh) >= BCD_12);
          end
        end else begin
          if (o_hh == BCD_12) begin
            o_hh <= 8'h01;
          end else if (o_hh == 8'h11) begin
            o_hh       <= BCD_12;
            o_pm       <= !o_pm;
            o_day_wrap <= o_pm;
          end else begin
            o_hh <= bcd_inc(o_hh);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rtc_bcd_core.sv
// Directed bench for rtc_bcd_core with CLK_DIV=4.
module tb_rtc_bcd_core;
  localparam int W = 28;

  logic       i_clk;
  logic       i_reset;
  logic       i_ena;
  logic       i_mode_24h;
  logic       i_wr;
  logic [1:0] i_sel;
  logic [7:0] i_in;
  logic [7:0] o_ss, o_mm, o_hh;
  logic       o_pm, o_tick, o_day_wrap, o_wr_err;

  typedef struct {
    logic       wr;
    logic [1:0] sel;
    logic [7:0] din;
    logic       mode;
    logic       ena;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;

  rtc_bcd_core #(.CLK_DIV(4), .PRESC_W(24)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_ena      (i_ena),
    .i_mode_24h (i_mode_24h),
    .i_wr       (i_wr),
    .i_sel      (i_sel),
    .i_in       (i_in),
    .o_ss       (o_ss),
    .o_mm       (o_mm),
    .o_hh       (o_hh),
    .o_pm       (o_pm),
    .o_tick     (o_tick),
    .o_day_wrap (o_day_wrap),
    .o_wr_err   (o_wr_err)
  );

  // Clock and reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [W-1:0] pack(input logic [7:0] ss, input logic [7:0] mm,
                                        input logic [7:0] hh, input logic pm, input logic tick,
                                        input logic wrap, input logic err);
    return {ss, mm, hh, pm, tick, wrap, err};
  endfunction

  // Driver: apply one cycle of inputs and advance to 1 time unit after the edge.
  task automatic drive(input logic rst, input logic wr, input logic [1:0] sel,
                       input logic [7:0] din, input logic mode, input logic ena);
    i_reset    = rst;
    i_wr       = wr;
    i_sel      = sel;
    i_in       = din;
    i_mode_24h = mode;
    i_ena      = ena;
    @(posedge i_clk);
    #1;
  endtask

  // Scoreboard: pop the oldest expectation and compare against the outputs.
  task automatic check(input string name);
    logic [W-1:0] exp;
    logic [W-1:0] act;
    exp = exp_q.pop_front();
    act = {o_ss, o_mm, o_hh, o_pm, o_tick, o_day_wrap, o_wr_err};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got ss=%h mm=%h hh=%h pm=%b tick=%b wrap=%b err=%b, expected ss=%h mm=%h hh=%h pm=%b tick=%b wrap=%b err=%b",
               name, act[27:20], act[19:12], act[11:4], act[3], act[2], act[1], act[0],
               exp[27:20], exp[19:12], exp[11:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic add(input logic wr, input logic [1:0] sel, input logic [7:0] din,
                     input logic mode, input logic ena,
                     input logic [7:0] ss, input logic [7:0] mm, input logic [7:0] hh,
                     input logic pm, input logic tick, input logic wrap, input logic err);
    vec_t v;
    v.wr = wr; v.sel = sel; v.din = din; v.mode = mode; v.ena = ena;
    v.exp = pack(ss, mm, hh, pm, tick, wrap, err);
    vecs.push_back(v);
  endtask

  initial begin
    // 24h rollover from 23:59:59
    add(1, 2'd2, 8'h23, 1, 0, 8'h03, 8'h00, 8'h23, 1, 0, 0, 0);
    add(1, 2'd1, 8'h59, 1, 0, 8'h03, 8'h59, 8'h23, 1, 0, 0, 0);
    add(1, 2'd0, 8'h59, 1, 0, 8'h59, 8'h59, 8'h23, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 2'd0, 8'h00, 1, 1, 8'h59, 8'h59, 8'h23, 1, 0, 0, 0);
    add(0, 2'd0, 8'h00, 1, 1, 8'h00, 8'h00, 8'h00, 0, 1, 1, 0);
    add(0, 2'd0, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    // pm write illegal in 24h
    add(1, 2'd3, 8'h01, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1);
    add(0, 2'd0, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    // switch to 12h: 00 -> 12 AM, then rejected hour writes
    add(0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h12, 0, 0, 0, 0);
    add(1, 2'd2, 8'h1A, 0, 0, 8'h00, 8'h00, 8'h12, 0, 0, 0, 1);
    add(1, 2'd2, 8'h13, 0, 0, 8'h00, 8'h00, 8'h12, 0, 0, 0, 1);
    // 11:59:59 AM -> 12:00:00 PM, no day wrap
    add(1, 2'd2, 8'h11, 0, 0, 8'h00, 8'h00, 8'h11, 0, 0, 0, 0);
    add(1, 2'd1, 8'h59, 0, 0, 8'h00, 8'h59, 8'h11, 0, 0, 0, 0);
    add(1, 2'd0, 8'h59, 0, 0, 8'h59, 8'h59, 8'h11, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 2'd0, 8'h00, 0, 1, 8'h59, 8'h59, 8'h11, 0, 0, 0, 0);
    add(0, 2'd0, 8'h00, 0, 1, 8'h00, 8'h00, 8'h12, 1, 1, 0, 0);
    // 11:59:59 PM -> 12:00:00 AM with day wrap
    add(1, 2'd2, 8'h11, 0, 0, 8'h00, 8'h00, 8'h11, 1, 0, 0, 0);
    add(1, 2'd1, 8'h59, 0, 0, 8'h00, 8'h59, 8'h11, 1, 0, 0, 0);
    add(1, 2'd0, 8'h59, 0, 0, 8'h59, 8'h59, 8'h11, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 2'd0, 8'h00, 0, 1, 8'h59, 8'h59, 8'h11, 1, 0, 0, 0);
    add(0, 2'd0, 8'h00, 0, 1, 8'h00, 8'h00, 8'h12, 0, 1, 1, 0);
    add(0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h12, 0, 0, 0, 0);
    // back to 24h: 12 AM -> 00; set 15:30:00
    add(0, 2'd0, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    add(1, 2'd2, 8'h15, 1, 0, 8'h00, 8'h00, 8'h15, 1, 0, 0, 0);
    add(1, 2'd1, 8'h30, 1, 0, 8'h00, 8'h30, 8'h15, 1, 0, 0, 0);
    add(1, 2'd0, 8'h00, 1, 0, 8'h00, 8'h30, 8'h15, 1, 0, 0, 0);
    // prescaler to 2, then two conversions while enabled; tick must land late
    add(0, 2'd0, 8'h00, 1, 1, 8'h00, 8'h30, 8'h15, 1, 0, 0, 0);
    add(0, 2'd0, 8'h00, 1, 1, 8'h00, 8'h30, 8'h15, 1, 0, 0, 0);
    add(0, 2'd0, 8'h00, 0, 1, 8'h00, 8'h30, 8'h03, 1, 0, 0, 0);
    add(0, 2'd0, 8'h00, 0, 1, 8'h00, 8'h30, 8'h03, 1, 0, 0, 0);
    add(0, 2'd0, 8'h00, 1, 1, 8'h00, 8'h30, 8'h15, 1, 0, 0, 0);
    add(0, 2'd0, 8'h00, 1, 1, 8'h01, 8'h30, 8'h15, 1, 1, 0, 0);
    add(0, 2'd0, 8'h00, 1, 0, 8'h01, 8'h30, 8'h15, 1, 0, 0, 0);
    // write during conversion is dropped
    add(1, 2'd1, 8'h10, 0, 0, 8'h01, 8'h30, 8'h03, 1, 0, 0, 1);
    add(0, 2'd0, 8'h00, 0, 0, 8'h01, 8'h30, 8'h03, 1, 0, 0, 0);
    // 12 PM <-> 12 in 24h
    add(1, 2'd2, 8'h12, 0, 0, 8'h01, 8'h30, 8'h12, 1, 0, 0, 0);
    add(0, 2'd0, 8'h00, 1, 0, 8'h01, 8'h30, 8'h12, 1, 0, 0, 0);
    // out-of-range seconds write
    add(1, 2'd0, 8'h60, 1, 0, 8'h01, 8'h30, 8'h12, 1, 0, 0, 1);
    add(0, 2'd0, 8'h00, 1, 0, 8'h01, 8'h30, 8'h12, 1, 0, 0, 0);

    // Reset in 24h mode
    i_reset = 1'b1; i_ena = 1'b0; i_mode_24h = 1'b1; i_wr = 1'b0; i_sel = 2'd0; i_in = 8'h00;
    drive(1, 0, 2'd0, 8'h00, 1, 0);
    exp_q.push_back(pack(8'h00, 8'h00, 8'h00, 0, 0, 0, 0));
    check("reset_24h");

    // Free-running seconds with CLK_DIV=4
    for (int c = 1; c <= 12; c++) begin
      drive(0, 0, 2'd0, 8'h00, 1, 1);
      exp_q.push_back(pack(8'(c / 4), 8'h00, 8'h00, 0, (c % 4) == 0, 0, 0));
      check($sformatf("prescale_c%0d", c));
    end

    // Table
    for (int i = 0; i < vecs.size(); i++) begin
      drive(0, vecs[i].wr, vecs[i].sel, vecs[i].din, vecs[i].mode, vecs[i].ena);
      exp_q.push_back(vecs[i].exp);
      check($sformatf("vec%0d", i));
    end

    // Reset overrides a concurrent write in 12h mode
    drive(1, 1, 2'd2, 8'h05, 0, 1);
    exp_q.push_back(pack(8'h00, 8'h00, 8'h12, 0, 0, 0, 0));
    check("reset_during_write");
    drive(0, 0, 2'd0, 8'h00, 0, 0);
    exp_q.push_back(pack(8'h00, 8'h00, 8'h12, 0, 0, 0, 0));
    check("after_reset_no_err");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
